// File: rtl/seq_alu.sv
// ----------------------------------------------------------------------------
// seq_alu
//
// This is the sequential, handshaked version of the 19-bit combinational ALU.
// It runs the same 17 opcodes, including branch, call and return target
// generation, at a datapath width set by WIDTH. Each result and its status
// flags are registered. They are delivered over a valid/ready pair, so the
// block can sit between decode and writeback/PC-update in a pipeline that
// is able to stall.
//
// Optional feature (macro SEQ_ALU_MULDIV_EN):
//   defined   : mul and div run as iterative operations that retire one bit
//               per cycle (shift-add multiply, restoring divide).
//   undefined : the block has no multiplier/divider datapath and no BUSY
//               state. Opcodes 00010 and 00011 report an illegal opcode in a
//               single cycle, and flag_dz stays 0.
//
// Parameters:
//   WIDTH      datapath width of operands, pc, immediate and results (>= 4)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operation request
//   in_ready   block can accept a request (high only in IDLE)
//   opcode     5-bit operation code
//   a, b       operands
//   pc         address of the issuing instruction
//   immediate  immediate / target address
//   out_valid  result available (high only in DONE)
//   out_ready  consumer takes the result
//   alu_out    result or next-PC value
//   ret_addr   return address (call only, else 0)
//   flag_zero  alu_out == 0
//   flag_carry carry out (add/inc) or borrow (sub/dec)
//   flag_dz    divide by zero
//   flag_ill   illegal opcode
// ----------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] immediate,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] ret_addr,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_dz,
    output logic             flag_ill
);

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_SUB   = 5'b00001;
    localparam logic [4:0] OP_MUL   = 5'b00010;
    localparam logic [4:0] OP_DIV   = 5'b00011;
    localparam logic [4:0] OP_INC   = 5'b00100;
    localparam logic [4:0] OP_DEC   = 5'b00101;
    localparam logic [4:0] OP_AND   = 5'b00110;
    localparam logic [4:0] OP_OR    = 5'b00111;
    localparam logic [4:0] OP_XOR   = 5'b01000;
    localparam logic [4:0] OP_NOT   = 5'b01001;
    localparam logic [4:0] OP_JMP   = 5'b01010;
    localparam logic [4:0] OP_BEQ   = 5'b01011;
    localparam logic [4:0] OP_BNE   = 5'b01100;
    localparam logic [4:0] OP_CALL  = 5'b01101;
    localparam logic [4:0] OP_RET   = 5'b01110;
    localparam logic [4:0] OP_LOAD  = 5'b01111;
    localparam logic [4:0] OP_STORE = 5'b10000;

`ifdef SEQ_ALU_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_DONE} state_e;
`endif

    state_e           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] alu_out_q;
    logic [WIDTH-1:0] ret_addr_q;
    logic             flag_zero_q;
    logic             flag_carry_q;
    logic             flag_dz_q;
    logic             flag_ill_q;

    // ------------------------------------------------------------------
    // Single-cycle result. This logic is computed straight from the
    // request inputs, and its outputs are captured only on the accept edge.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sc_res_d;
    logic [WIDTH-1:0] sc_ret_d;
    logic             sc_carry_d;
    logic             sc_dz_d;
    logic             sc_ill_d;
    logic [WIDTH-1:0] pc_inc;

    assign pc_inc = pc + WIDTH'(1);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the case can leave a latch behind.
        sc_res_d   = '0;
        sc_ret_d   = '0;
        sc_carry_d = 1'b0;
        sc_dz_d    = 1'b0;
        sc_ill_d   = 1'b0;
        case (opcode)
            // The top bit of the widened sum or difference is the carry or borrow.
            OP_ADD:   {sc_carry_d, sc_res_d} = {1'b0, a} + {1'b0, b};
            OP_SUB:   {sc_carry_d, sc_res_d} = {1'b0, a} - {1'b0, b};
`ifdef SEQ_ALU_MULDIV_EN
            // A mul or div reaches this path only when b == 0. Any product
            // with zero is 0. A divide by zero returns all ones.
            OP_MUL:   sc_res_d = '0;
            OP_DIV: begin
                sc_res_d = '1;
                sc_dz_d  = 1'b1;
            end
`else
            OP_MUL, OP_DIV: sc_ill_d = 1'b1;
`endif
            OP_INC:   {sc_carry_d, sc_res_d} = {1'b0, a} + (WIDTH+1)'(1);
            OP_DEC:   {sc_carry_d, sc_res_d} = {1'b0, a} - (WIDTH+1)'(1);
            OP_AND:   sc_res_d = a & b;
            OP_OR:    sc_res_d = a | b;
            OP_XOR:   sc_res_d = a ^ b;
            OP_NOT:   sc_res_d = ~a;
            OP_JMP:   sc_res_d = immediate;
            OP_BEQ:   sc_res_d = (a == b) ? immediate : pc_inc;
            OP_BNE:   sc_res_d = (a != b) ? immediate : pc_inc;
            OP_CALL: begin
                sc_res_d = immediate;
                sc_ret_d = pc_inc;
            end
            OP_RET:   sc_res_d = a;
            OP_LOAD:  sc_res_d = immediate;
            OP_STORE: sc_res_d = immediate;
            default:  sc_ill_d = 1'b1;
        endcase
    end

`ifdef SEQ_ALU_MULDIV_EN
    // ------------------------------------------------------------------
    // Iterative datapath shared by mul and div.
    //   mul: acc = partial product, x = multiplicand (shifts left),
    //        y = multiplier (shifts right, LSB selects the add).
    //   div: acc = partial remainder, x = dividend shifting out at the top
    //        while quotient bits shift in at the bottom, y = divisor.
    // ------------------------------------------------------------------
    localparam int CW = $clog2(WIDTH + 1);

    logic             is_mul_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] iter_res;

    always_comb begin
        acc_d     = acc_q;
        x_d       = x_q;
        y_d       = y_q;
        rem_shift = {acc_q, x_q[WIDTH-1]};
        if (is_mul_q) begin
            if (y_q[0]) begin
                acc_d = acc_q + x_q;
            end
            x_d = {x_q[WIDTH-2:0], 1'b0};
            y_d = {1'b0, y_q[WIDTH-1:1]};
        end else if (rem_shift >= {1'b0, y_q}) begin
            // rem_shift < 2*y here, so the difference always fits in WIDTH bits.
            acc_d = rem_shift[WIDTH-1:0] - y_q;
            x_d   = {x_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = rem_shift[WIDTH-1:0];
            x_d   = {x_q[WIDTH-2:0], 1'b0};
        end
    end

    assign iter_res = is_mul_q ? acc_d : x_d;
`endif

    // ------------------------------------------------------------------
    // Control FSM. All outputs are registered and change only at the
    // accept edge, at the completion edge, or on the DONE->IDLE handoff.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register in this block samples values from before the edge.
        if (rst) begin
            // The datapath registers are reset as well, so an aborted op
            // leaves nothing behind.
            state_q      <= S_IDLE;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            alu_out_q    <= '0;
            ret_addr_q   <= '0;
            flag_zero_q  <= 1'b0;
            flag_carry_q <= 1'b0;
            flag_dz_q    <= 1'b0;
            flag_ill_q   <= 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
            is_mul_q     <= 1'b0;
            cnt_q        <= '0;
            acc_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
                        if ((opcode == OP_MUL || opcode == OP_DIV) && b != '0) begin
                            is_mul_q <= (opcode == OP_MUL);
                            acc_q    <= '0;
                            x_q      <= a;
                            y_q      <= b;
                            cnt_q    <= CW'(WIDTH);
                            state_q  <= S_BUSY;
                        end else
`endif
                        begin
                            alu_out_q    <= sc_res_d;
                            ret_addr_q   <= sc_ret_d;
                            flag_zero_q  <= (sc_res_d == '0);
                            flag_carry_q <= sc_carry_d;
                            flag_dz_q    <= sc_dz_d;
                            flag_ill_q   <= sc_ill_d;
                            out_valid_q  <= 1'b1;
                            state_q      <= S_DONE;
                        end
                    end
                end
`ifdef SEQ_ALU_MULDIV_EN
                S_BUSY: begin
                    acc_q <= acc_d;
                    x_q   <= x_d;
                    y_q   <= y_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        // The last step finishes here, and its result goes straight out.
                        alu_out_q    <= iter_res;
                        ret_addr_q   <= '0;
                        flag_zero_q  <= (iter_res == '0);
                        flag_carry_q <= 1'b0;
                        flag_dz_q    <= 1'b0;
                        flag_ill_q   <= 1'b0;
                        out_valid_q  <= 1'b1;
                        state_q      <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    // in_ready stays low this cycle, so the result is consumed
                    // and the next request is accepted on different edges.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign alu_out    = alu_out_q;
    assign ret_addr   = ret_addr_q;
    assign flag_zero  = flag_zero_q;
    assign flag_carry = flag_carry_q;
    assign flag_dz    = flag_dz_q;
    assign flag_ill   = flag_ill_q;

endmodule

// File: tb/tb_seq_alu.sv
// ----------------------------------------------------------------------------
// tb_seq_alu
//
// Directed testbench for seq_alu at WIDTH=19. Each scenario task drives its
// own stimulus and compares the observed outputs with hand-computed values.
// The checks for mul and div follow SEQ_ALU_MULDIV_EN: with the macro they
// expect the iterative results, and without it they expect illegal-opcode
// results.
// ----------------------------------------------------------------------------
module tb_seq_alu;

    localparam int W  = 19;
    localparam int OW = 2 + W + W + 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   opcode;
    logic [W-1:0] a, b, pc, immediate;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_out, ret_addr;
    logic         flag_zero, flag_carry, flag_dz, flag_ill;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .a          (a),
        .b          (b),
        .pc         (pc),
        .immediate  (immediate),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_out    (alu_out),
        .ret_addr   (ret_addr),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .flag_dz    (flag_dz),
        .flag_ill   (flag_ill)
    );

    // Observed bundle: {in_ready, out_valid, alu_out, ret_addr, zero, carry, dz, ill}
    wire [OW-1:0] obs = {in_ready, out_valid, alu_out, ret_addr,
                         flag_zero, flag_carry, flag_dz, flag_ill};

    typedef struct {
        logic [4:0]   op;
        logic [W-1:0] a, b, pc, imm;
        logic [W-1:0] exp_out, exp_ret;
        logic [3:0]   exp_flags;   // {zero, carry, dz, ill}
        int           exp_lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [4:0] op, input logic [W-1:0] va, vb, vpc, vimm,
                                input logic [W-1:0] eo, er, input logic [3:0] ef, input int el);
        vec_t v;
        v.op = op; v.a = va; v.b = vb; v.pc = vpc; v.imm = vimm;
        v.exp_out = eo; v.exp_ret = er; v.exp_flags = ef; v.exp_lat = el;
        return v;
    endfunction

    // Issues one request from IDLE, then scrambles the inputs after the accept
    // edge. Returns the number of cycles until out_valid, counting the accept
    // cycle as 1, and whether in_ready was seen high while waiting.
    task automatic do_op(input vec_t v, output int lat, output bit saw_ready);
        opcode = v.op; a = v.a; b = v.b; pc = v.pc; immediate = v.imm;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        opcode    = 5'b01000;
        a         = W'($urandom);
        b         = W'($urandom);
        pc        = W'($urandom);
        immediate = W'($urandom);
        lat = 1;
        saw_ready = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) saw_ready = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [OW-1:0] exp;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        opcode = '0; a = '0; b = '0; pc = '0; immediate = '0;
        repeat (3) @(posedge clk);
        #1;
        exp = {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 4'b0000};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL reset_values: got %h expected %h", obs, exp);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL idle_after_reset: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_vectors();
        int lat;
        bit saw;
        logic [OW-1:0] exp;
        vecs.push_back(mk(5'b00000, 19'h7FFFF, 19'h00001, 0, 0, 19'h00000, 0, 4'b1100, 1)); // add overflow
        vecs.push_back(mk(5'b00000, 19'h00002, 19'h00003, 0, 0, 19'h00005, 0, 4'b0000, 1)); // add
        vecs.push_back(mk(5'b00001, 19'h00005, 19'h00007, 0, 0, 19'h7FFFE, 0, 4'b0100, 1)); // sub borrow
        vecs.push_back(mk(5'b00001, 19'h00007, 19'h00007, 0, 0, 19'h00000, 0, 4'b1000, 1)); // sub zero
        vecs.push_back(mk(5'b00100, 19'h7FFFF, 19'h00000, 0, 0, 19'h00000, 0, 4'b1100, 1)); // inc wrap
        vecs.push_back(mk(5'b00101, 19'h00000, 19'h00000, 0, 0, 19'h7FFFF, 0, 4'b0100, 1)); // dec borrow
        vecs.push_back(mk(5'b00101, 19'h00001, 19'h00000, 0, 0, 19'h00000, 0, 4'b1000, 1)); // dec to 0
        vecs.push_back(mk(5'b00110, 19'h5A5A5, 19'h0FF0F, 0, 0, 19'h0A505, 0, 4'b0000, 1)); // and
        vecs.push_back(mk(5'b00111, 19'h12340, 19'h00005, 0, 0, 19'h12345, 0, 4'b0000, 1)); // or
        vecs.push_back(mk(5'b01000, 19'h7FFFF, 19'h12345, 0, 0, 19'h6DCBA, 0, 4'b0000, 1)); // xor
        vecs.push_back(mk(5'b01001, 19'h12345, 19'h00000, 0, 0, 19'h6DCBA, 0, 4'b0000, 1)); // not
        vecs.push_back(mk(5'b01001, 19'h7FFFF, 19'h00000, 0, 0, 19'h00000, 0, 4'b1000, 1)); // not -> 0
        vecs.push_back(mk(5'b01010, 0, 0, 19'h00100, 19'h02000, 19'h02000, 0, 4'b0000, 1)); // jmp
        vecs.push_back(mk(5'b01011, 3, 3, 19'h00010, 19'h00040, 19'h00040, 0, 4'b0000, 1)); // beq taken
        vecs.push_back(mk(5'b01011, 3, 4, 19'h00010, 19'h00040, 19'h00011, 0, 4'b0000, 1)); // beq not
        vecs.push_back(mk(5'b01100, 3, 3, 19'h00010, 19'h00040, 19'h00011, 0, 4'b0000, 1)); // bne not
        vecs.push_back(mk(5'b01100, 3, 4, 19'h00010, 19'h00040, 19'h00040, 0, 4'b0000, 1)); // bne taken
        vecs.push_back(mk(5'b01101, 0, 0, 19'h00100, 19'h02000, 19'h02000, 19'h00101, 4'b0000, 1)); // call
        vecs.push_back(mk(5'b01101, 0, 0, 19'h7FFFF, 19'h00000, 19'h00000, 19'h00000, 4'b1000, 1)); // call wrap
        vecs.push_back(mk(5'b01110, 19'h01234, 0, 19'h00050, 19'h00060, 19'h01234, 0, 4'b0000, 1)); // ret
        vecs.push_back(mk(5'b01111, 0, 0, 0, 19'h03333, 19'h03333, 0, 4'b0000, 1)); // load
        vecs.push_back(mk(5'b10000, 0, 0, 0, 19'h04444, 19'h04444, 0, 4'b0000, 1)); // store
        vecs.push_back(mk(5'b10001, 19'h00005, 19'h00005, 0, 0, 19'h00000, 0, 4'b1001, 1)); // illegal
        vecs.push_back(mk(5'b11111, 19'h00005, 19'h00005, 0, 0, 19'h00000, 0, 4'b1001, 1)); // illegal
`ifdef SEQ_ALU_MULDIV_EN
        vecs.push_back(mk(5'b00010, 19'd300, 19'd500, 0, 0, 19'd150000, 0, 4'b0000, 20)); // mul
        vecs.push_back(mk(5'b00010, 19'h7FFFF, 19'h7FFFF, 0, 0, 19'h00001, 0, 4'b0000, 20)); // mul wrap
        vecs.push_back(mk(5'b00010, 19'd5, 19'd0, 0, 0, 19'h00000, 0, 4'b1000, 1)); // mul by 0
        vecs.push_back(mk(5'b00011, 19'd1000, 19'd7, 0, 0, 19'd142, 0, 4'b0000, 20)); // div
        vecs.push_back(mk(5'b00011, 19'd3, 19'd7, 0, 0, 19'd0, 0, 4'b1000, 20)); // div -> 0
        vecs.push_back(mk(5'b00011, 19'h7FFFF, 19'd1, 0, 0, 19'h7FFFF, 0, 4'b0000, 20)); // div by 1
        vecs.push_back(mk(5'b00011, 19'd5, 19'd0, 0, 0, 19'h7FFFF, 0, 4'b0010, 1)); // div by 0
`else
        vecs.push_back(mk(5'b00010, 19'd300, 19'd500, 0, 0, 19'h00000, 0, 4'b1001, 1)); // mul absent
        vecs.push_back(mk(5'b00011, 19'd1000, 19'd7, 0, 0, 19'h00000, 0, 4'b1001, 1)); // div absent
        vecs.push_back(mk(5'b00011, 19'd5, 19'd0, 0, 0, 19'h00000, 0, 4'b1001, 1)); // div by 0 absent
`endif
        foreach (vecs[i]) begin
            do_op(vecs[i], lat, saw);
            n_cmp++;
            if (lat !== vecs[i].exp_lat) begin
                n_bad++;
                $display("FAIL vec%0d_latency op=%b: got %0d expected %0d", i, vecs[i].op, lat, vecs[i].exp_lat);
            end
            n_cmp++;
            if (saw !== 1'b0) begin
                n_bad++;
                $display("FAIL vec%0d_ready_while_waiting op=%b: got 1 expected 0", i, vecs[i].op);
            end
            exp = {1'b0, 1'b1, vecs[i].exp_out, vecs[i].exp_ret, vecs[i].exp_flags};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL vec%0d_result op=%b: got %h expected %h", i, vecs[i].op, obs, exp);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit saw;
        logic [OW-1:0] exp;
        do_op(mk(5'b01000, 19'h0F0F0, 19'h00FF0, 0, 0, 0, 0, 0, 0), lat, saw);
        exp = {1'b0, 1'b1, 19'h0FF00, {W{1'b0}}, 4'b0000};
        // Offer a competing request while the result waits. It must not be taken.
        opcode = 5'b00000; a = 19'd1; b = 19'd1; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL backpressure_hold_cycle%0d: got %h expected %h", i, obs, exp);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL backpressure_release: got %b expected 10", {in_ready, out_valid});
        end
    endtask

    task automatic test_back_to_back();
        int n_rdy = 0;
        int n_val = 0;
        opcode = 5'b00000; a = 19'd1; b = 19'd2; pc = '0; immediate = '0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (in_ready)  n_rdy++;
            if (out_valid) n_val++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++;
        if (n_rdy !== 5 || n_val !== 5) begin
            n_bad++;
            $display("FAIL back_to_back_rate: got ready=%0d valid=%0d expected 5/5", n_rdy, n_val);
        end
        n_cmp++;
        if (alu_out !== 19'd3) begin
            n_bad++;
            $display("FAIL back_to_back_result: got %h expected %h", alu_out, 19'd3);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        bit saw;
        logic [OW-1:0] exp;
`ifdef SEQ_ALU_MULDIV_EN
        opcode = 5'b00010;   // mul 300 x 500, aborted while BUSY
`else
        opcode = 5'b01000;   // xor left waiting in DONE, then reset
`endif
        a = 19'd300; b = 19'd500; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp = {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 4'b0000};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL reset_mid_op: got %h expected %h", obs, exp);
        end
        // The aborted op must never complete later on.
        repeat (25) @(posedge clk);
        #1;
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL reset_no_late_result: got %h expected %h", obs, exp);
        end
        do_op(mk(5'b00000, 19'd2, 19'd3, 0, 0, 0, 0, 0, 0), lat, saw);
        exp = {1'b0, 1'b1, 19'd5, {W{1'b0}}, 4'b0000};
        n_cmp++;
        if (obs !== exp || lat !== 1) begin
            n_bad++;
            $display("FAIL add_after_reset: got %h lat=%0d expected %h lat=1", obs, lat, exp);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
